// File: rtl/cic_decim_scheduler.sv
// cic_decim_scheduler: gates sample strobes into CIC eni/eno, flushes and settles the CIC on ratio changes
module cic_decim_scheduler #(
  parameter int RMAX = 64,
  parameter int R_DEF = 4,
  parameter int N = 2,
  parameter int M = 1,
  parameter int FLUSH_CYC = 2,
  localparam int RW = $clog2(RMAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_stb,
  input  logic [RW-1:0] cfg_r,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  output logic          cic_rst,
  output logic          eni,
  output logic          eno,
  output logic          out_valid,
  output logic [RW-1:0] r_active,
  output logic          busy
);
  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam int SW = $clog2(N * M + 2);
  typedef enum logic [1:0] {FLUSH, SETTLE, RUN} state_t;
  state_t        state;
  logic [FW-1:0] fc;
  logic [SW-1:0] sc;
  logic [RW-1:0] ph;
  logic [RW-1:0] r_new;
  logic          ov_q;
  logic          hs;
  // outputs are forced to their reset values while rst is low, not one clock later
  always_comb begin
    cfg_ready = (state != FLUSH) & rst;
    hs        = cfg_valid & cfg_ready;
    cic_rst   = (state == FLUSH) | ~rst;
    busy      = (state != RUN) | ~rst;
    eni       = in_stb & (state != FLUSH) & rst;
    eno       = eni & (ph == r_active - 1'b1);
    out_valid = ov_q & rst;
    r_new     = (cfg_r == '0) ? RW'(1) : (cfg_r > RW'(RMAX)) ? RW'(RMAX) : cfg_r;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FLUSH;
      fc       <= '0;
      sc       <= '0;
      ph       <= '0;
      r_active <= RW'(R_DEF);
      ov_q     <= 1'b0;
    end else begin
      ov_q <= eno & (state == RUN) & ~hs;
      if (eni) ph <= eno ? '0 : ph + 1'b1;
      if (hs) begin
        r_active <= r_new;
        state    <= FLUSH;
        fc       <= '0;
      end else begin
        case (state)
          FLUSH: begin
            if (fc == FW'(FLUSH_CYC - 1)) begin
              state <= SETTLE;
              ph    <= '0;
              sc    <= '0;
            end else fc <= fc + 1'b1;
          end
          SETTLE: begin
            if (eno) begin
              sc <= sc + 1'b1;
              if (sc == SW'(N * M)) state <= RUN;
            end
          end
          RUN: state <= RUN;
          default: state <= FLUSH;
        endcase
      end
    end
  end
endmodule
